// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 row-scan keypad: key codes, active-low
// row/column codes and the emulator state encoding. The keypad scanner
// imports the same package so both ends agree on key numbering.
package keypad_pkg;

    // Key code = row*4 + col, row in [3:2], col in [1:0].
    typedef logic [3:0] key_t;

    // Column lines with no key pressed.
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Row lines as driven by the scanner, one bit low at a time.
    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One-hot-low code for a 2-bit row (or column) index.
    function automatic logic [3:0] row_onehot_n(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Command port of the keypad emulator: one key press per valid/ready
// transfer, plus status back to the game controller.
interface keypad_emulator_if;
    import keypad_pkg::*;

    logic cmd_valid;
    key_t cmd_key;
    logic cmd_ready;
    logic busy;
    logic done;
    logic err;

    // Controller side issues commands and watches status.
    modport master (
        output cmd_valid, cmd_key,
        input  cmd_ready, busy, done, err
    );

    // Emulator side accepts commands and reports status.
    modport slave (
        input  cmd_valid, cmd_key,
        output cmd_ready, busy, done, err
    );

endinterface

// File: rtl/keypad_scan_sync.sv
// Row-line observer: registers fila, flags the first cycle of each scan
// (row 0 newly driven) and tells whether fila is a legal one-hot-low code.
module keypad_scan_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic       scan_start,
    output logic       fila_valid
);

    logic [3:0] fila_q;

    // Previous-cycle row lines, used to detect the rising edge into row 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            fila_q <= COL_IDLE;
        end else begin
            fila_q <= fila;
        end
    end

    assign scan_start = (fila == ROW0) && (fila_q != ROW0);
    assign fila_valid = (fila == ROW0) || (fila == ROW1) ||
                        (fila == ROW2) || (fila == ROW3);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: answers the scanner's row strobes on the column lines
// as if one key were physically held for HOLD_SCANS whole scans, then
// guarantees GAP_SCANS released scans before reporting done.
// Optional scanner watchdog: define KEYPAD_EMU_TIMEOUT_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_SCANS  = 4,
    parameter int GAP_SCANS   = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         fila,
    output logic [3:0]         columna,
    keypad_emulator_if.slave   cmd
);

    localparam int MAX_SCANS = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int CNT_W     = $clog2(MAX_SCANS + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_SCANS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SCANS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    key_t             key_q, key_n;
    logic             scan_start, fila_valid;
    logic             press_on, done_c, timeout_hit;

    keypad_scan_sync u_scan_sync (
        .clk        (clk),
        .rst        (rst),
        .fila       (fila),
        .scan_start (scan_start),
        .fila_valid (fila_valid)
    );

    // Scan counter saturates instead of wrapping.
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

`ifdef KEYPAD_EMU_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    logic            err_q;

    // Abort when the scanner has not started a scan for TIMEOUT_CYC clocks.
    assign timeout_hit = (state != IDLE) && !scan_start &&
                         (wd == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: cleared in IDLE and on each scan start, counts otherwise.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || scan_start) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    // Sticky scanner-timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign cmd.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign cmd.err     = 1'b0;
`endif

    // State, scan counter and latched key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            key_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key_q <= key_n;
        end
    end

    // Next state, counter update, press window and done pulse.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n  = state;
        cnt_n    = cnt;
        key_n    = key_q;
        press_on = 1'b0;
        done_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    key_n   = cmd.cmd_key;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                // The aligning scan start is already part of the first held
                // scan, so its row-0 slot is pressed too.
                if (scan_start) begin
                    cnt_n    = '0;
                    state_n  = PRESS;
                    press_on = 1'b1;
                end
            end
            PRESS: begin
                press_on = 1'b1;
                if (scan_start) begin
                    if (cnt == HOLD_LAST) begin
                        // Hold complete: this row-0 slot is already released.
                        cnt_n    = '0;
                        state_n  = GAP;
                        press_on = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            GAP: begin
                if (scan_start) begin
                    if (cnt == GAP_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        done_c  = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout_hit) begin
            state_n  = IDLE;
            cnt_n    = '0;
            press_on = 1'b0;
            done_c   = 1'b0;
        end
    end

    // Zero-latency column response: the scanner may sample the same cycle
    // it drives a row. Reset releases the key in the cycle it is sampled.
    assign columna = (press_on && !rst && fila_valid &&
                      fila == row_onehot_n(key_q[3:2])) ?
                     row_onehot_n(key_q[1:0]) : COL_IDLE;

    assign cmd.done      = done_c && !rst;
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);

endmodule
